uart_8250_tx: RTL and testbench

//  8250-compatible transmit path: Transmitter Holding Register (THR) + Transmit Shift Register (TSR).

---
 rtl/uart_8250_pkg.sv | 24 ++
 rtl/uart_8250_tx_if.sv | 26 ++
 rtl/uart_8250_parity_gen.sv | 29 ++
 rtl/uart_8250_tx.sv | 146 ++++++++++++++
 tb/tb_uart_8250_tx.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_8250_pkg.sv
// Shared types and helpers for the 8250-style UART transmit path.
// Latency/backpressure: n/a (declarations only).
// Contents: FSM state enum, LCR word-length codes, wls_to_nbits().
package uart_8250_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] WLS_5 = 2'd0;
  localparam logic [1:0] WLS_6 = 2'd1;
  localparam logic [1:0] WLS_7 = 2'd2;
  localparam logic [1:0] WLS_8 = 2'd3;

  // Number of data bits carried for a given LCR word-length code (5..8).
  function automatic logic [3:0] wls_to_nbits(input logic [1:0] wls);
    return 4'd5 + {2'b00, wls};
  endfunction

endpackage

// File: rtl/uart_8250_tx_if.sv
// Register-file side bundle of the UART transmitter: THR write, LCR fields, status.
// Latency: n/a (wires only). Backpressure: none; thre is the only flow indication.
// master = APB register file, slave = transmitter (drives txd, thre, temt).
interface uart_8250_tx_if;
  logic [7:0] thr_wdata;
  logic       thr_we;
  logic [1:0] lcr_wls;
  logic       lcr_stb;
  logic       lcr_pen;
  logic       lcr_eps;
  logic       lcr_sp;
  logic       lcr_bc;
  logic       txd;
  logic       thre;
  logic       temt;

  modport master (
    output thr_wdata, thr_we, lcr_wls, lcr_stb, lcr_pen, lcr_eps, lcr_sp, lcr_bc,
    input  txd, thre, temt
  );

  modport slave (
    input  thr_wdata, thr_we, lcr_wls, lcr_stb, lcr_pen, lcr_eps, lcr_sp, lcr_bc,
    output txd, thre, temt
  );
endinterface

// File: rtl/uart_8250_parity_gen.sv
// Parity bit for one UART character; bits above the word length are masked off.
// Latency: combinational. Backpressure: none.
// Ports: data[7:0], wls (word length code), eps (1=even), sp (stick) -> parity.
module uart_8250_parity_gen
  import uart_8250_pkg::*;
(
  input  logic [7:0] data,
  input  logic [1:0] wls,
  input  logic       eps,
  input  logic       sp,
  output logic       parity
);

  logic [7:0] mask;
  logic       red;

  always_comb begin
    mask = 8'hFF >> (WLS_8 - wls);
    red  = ^(data & mask);
    if (sp) begin
      parity = ~eps;          // stick parity: constant bit, inverse of eps
    end else if (eps) begin
      parity = red;
    end else begin
      parity = ~red;
    end
  end

endmodule

// File: rtl/uart_8250_tx.sv
// 8250 transmit path: THR + TSR, serialises start/data/parity/stop at the 16x baud tick.
// Latency: THR->TSR transfer 1 clk after write when idle; txd registered (1 clk after state change).
// Backpressure: none; a write while thre=0 overwrites THR. Ports: clk, rst, baud_tick, bus (slave).
module uart_8250_tx
  import uart_8250_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           baud_tick,
  uart_8250_tx_if.slave  bus
);

  localparam int TW = $clog2(2 * OVERSAMPLE);
  localparam logic [TW:0] LEN_1  = (TW+1)'(OVERSAMPLE);
  localparam logic [TW:0] LEN_15 = (TW+1)'(OVERSAMPLE * 3 / 2);
  localparam logic [TW:0] LEN_2  = (TW+1)'(2 * OVERSAMPLE);

  tx_state_e     state, state_nxt;
  logic [TW-1:0] tick_cnt, tick_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    thr, tsr;
  logic          thre_q, txd_q;
  logic [1:0]    wls_q;
  logic          stb_q, pen_q, eps_q, sp_q;
  logic          load, bit_done, par_bit, txd_bit;
  logic [TW:0]   stop_len, bit_len;
  logic [3:0]    nbits;

  uart_8250_parity_gen u_par (
    .data   (tsr),
    .wls    (wls_q),
    .eps    (eps_q),
    .sp     (sp_q),
    .parity (par_bit)
  );

  // Length of the current bit in baud ticks; only STOP can differ from one bit time.
  always_comb begin
    stop_len = LEN_1;
    if (stb_q) stop_len = (wls_q == WLS_5) ? LEN_15 : LEN_2;
    bit_len  = (state == STOP) ? stop_len : LEN_1;
    bit_done = baud_tick && (state != IDLE) && ({1'b0, tick_cnt} == bit_len - 1'b1);
    nbits    = wls_to_nbits(wls_q);
  end

  // Next-state logic. load marks the THR->TSR transfer, which happens from IDLE
  // at once, or straight out of STOP so back-to-back frames have no idle gap.
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    load      = 1'b0;
    if (baud_tick && state != IDLE) tick_nxt = bit_done ? '0 : tick_cnt + 1'b1;
    case (state)
      IDLE: begin
        if (!thre_q) begin
          load      = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_done) begin
          state_nxt = DATA;
          bit_nxt   = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if ({1'b0, bit_cnt} == nbits - 4'd1) state_nxt = pen_q ? PARITY : STOP;
          else bit_nxt = bit_cnt + 1'b1;
        end
      end
      PARITY: begin
        if (bit_done) state_nxt = STOP;
      end
      STOP: begin
        if (bit_done) begin
          if (!thre_q) begin
            load      = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (state)
      START:   txd_bit = 1'b0;
      DATA:    txd_bit = tsr[bit_cnt];
      PARITY:  txd_bit = par_bit;
      default: txd_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      bit_cnt  <= bit_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      thr    <= '0;
      tsr    <= '0;
      thre_q <= 1'b1;
      txd_q  <= 1'b1;
      wls_q  <= '0;
      stb_q  <= 1'b0;
      pen_q  <= 1'b0;
      eps_q  <= 1'b0;
      sp_q   <= 1'b0;
    end else begin
      if (bus.thr_we) thr <= bus.thr_wdata;
      // A write coinciding with a transfer keeps THR full; the old byte goes to TSR.
      if (bus.thr_we) thre_q <= 1'b0;
      else if (load)  thre_q <= 1'b1;
      if (load) begin
        tsr   <= thr;
        wls_q <= bus.lcr_wls;
        stb_q <= bus.lcr_stb;
        pen_q <= bus.lcr_pen;
        eps_q <= bus.lcr_eps;
        sp_q  <= bus.lcr_sp;
      end
      // Break overrides the line but the frame keeps running underneath.
      txd_q <= bus.lcr_bc ? 1'b0 : txd_bit;
    end
  end

  assign bus.txd  = txd_q;
  assign bus.thre = thre_q;
  assign bus.temt = thre_q && (state == IDLE);

endmodule

// File: tb/tb_uart_8250_tx.sv
// Directed bench for uart_8250_tx: frame formats, stop lengths, back-to-back, break, reset.
// Each bit is sampled on its first and last clock; expected frames are written out by hand.
// Ports: none (top level bench).
module tb_uart_8250_tx;

  logic clk;
  logic rst;
  logic baud_tick;
  int   tick_div = 1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  uart_8250_tx_if bus ();

  uart_8250_tx #(.OVERSAMPLE(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .bus       (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud tick: high in the cycle after an edge where cyc is a multiple of tick_div.
  initial begin
    baud_tick = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      baud_tick = ((cyc % tick_div) == 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_lcr(input logic [1:0] wls, input logic stb, input logic pen,
                         input logic eps, input logic sp);
    bus.lcr_wls = wls;
    bus.lcr_stb = stb;
    bus.lcr_pen = pen;
    bus.lcr_eps = eps;
    bus.lcr_sp  = sp;
  endtask

  // Returns 1 ns after the edge that loads THR.
  task automatic write_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    bus.thr_wdata = b;
    bus.thr_we    = 1'b1;
    @(posedge clk);
    #1;
    bus.thr_we    = 1'b0;
  endtask

  // From just after the THR-load edge to the edge where txd shows the start bit.
  task automatic lead_in(input string tag);
    @(negedge clk);
    check($sformatf("%s_thre_after_wr", tag), bus.thre, 0);
    check($sformatf("%s_temt_after_wr", tag), bus.temt, 0);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("%s_thre_after_xfer", tag), bus.thre, 1);
    check($sformatf("%s_txd_before_start", tag), bus.txd, 1);
    @(posedge clk);
  endtask

  // bits[0] is the start bit, bits[nb-1] the stop bit; called at the start-bit edge,
  // returns at the edge where the following bit would begin.
  task automatic check_frame(input string tag, input logic [11:0] bits, input int nb,
                             input int bit_clk, input int stop_clk, input logic temt_end);
    for (int i = 0; i < nb; i++) begin
      int len;
      len = (i == nb - 1) ? stop_clk : bit_clk;
      @(negedge clk);
      check($sformatf("%s_b%0d_first", tag, i), bus.txd, bits[i]);
      if (i == nb - 1) check($sformatf("%s_temt_in_stop", tag), bus.temt, 0);
      repeat (len - 1) @(posedge clk);
      @(negedge clk);
      check($sformatf("%s_b%0d_last", tag, i), bus.txd, bits[i]);
      if (i == nb - 1) check($sformatf("%s_temt_end", tag), bus.temt, temt_end);
      @(posedge clk);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.thr_we    = 1'b0;
    bus.thr_wdata = 8'h00;
    bus.lcr_bc    = 1'b0;
    set_lcr(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_txd",  bus.txd,  1);
    check("rst_thre", bus.thre, 1);
    check("rst_temt", bus.temt, 1);

    // 1: 8N1 0x55
    write_byte(8'h55);
    lead_in("t1");
    check_frame("t1", {1'b1, 8'h55, 1'b0}, 10, 16, 16, 1'b1);

    // 2: 7E1 0x83, bit 7 dropped, parity even over 0000011 -> 0
    set_lcr(2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    write_byte(8'h83);
    lead_in("t2");
    check_frame("t2", {1'b1, 1'b0, 7'b0000011, 1'b0}, 10, 16, 16, 1'b1);

    // 3: 5 bits, odd parity, 1.5 stop; 11111 -> odd parity 0; then stick parity -> 1
    set_lcr(2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    write_byte(8'h1F);
    lead_in("t3a");
    check_frame("t3a", {1'b1, 1'b0, 5'b11111, 1'b0}, 8, 16, 24, 1'b1);
    set_lcr(2'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    write_byte(8'h1F);
    lead_in("t3b");
    check_frame("t3b", {1'b1, 1'b1, 5'b11111, 1'b0}, 8, 16, 24, 1'b1);

    // 4: back-to-back, second byte overwritten before it is transferred
    set_lcr(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    write_byte(8'hA1);
    lead_in("t4");
    fork
      begin
        check_frame("t4f1", {1'b1, 8'hA1, 1'b0}, 10, 16, 16, 1'b0);
        check_frame("t4f2", {1'b1, 8'hC6, 1'b0}, 10, 16, 16, 1'b1);
      end
      begin
        repeat (40) @(posedge clk);
        write_byte(8'h3C);
        @(negedge clk);
        check("t4_thre_pending", bus.thre, 0);
        repeat (20) @(posedge clk);
        write_byte(8'hC6);
        @(negedge clk);
        check("t4_thre_overwrite", bus.thre, 0);
        repeat (120) @(posedge clk);
        @(negedge clk);
        check("t4_thre_after_xfer2", bus.thre, 1);
        check("t4_temt_frame2", bus.temt, 0);
      end
    join

    // 5: tick every 4 clk, break for 10 clk inside data bit 2 of 0xFF
    tick_div = 4;
    do begin
      @(posedge clk);
      #2;
    end while ((cyc % 4) != 2);
    write_byte(8'hFF);
    lead_in("t5");
    fork
      check_frame("t5", {1'b1, 8'hFF, 1'b0}, 10, 64, 64, 1'b1);
      begin
        repeat (200) @(posedge clk);
        #1 bus.lcr_bc = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t5_break_low", bus.txd, 0);
        repeat (7) @(posedge clk);
        #1 bus.lcr_bc = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t5_break_release", bus.txd, 1);
      end
    join
    tick_div = 1;

    // 6: reset mid-DATA with a byte pending, then a clean 0x00 frame
    write_byte(8'hF0);
    lead_in("t6");
    repeat (30) @(posedge clk);
    write_byte(8'h99);
    @(negedge clk);
    check("t6_pending", bus.thre, 0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t6_rst_txd",  bus.txd,  1);
    check("t6_rst_thre", bus.thre, 1);
    check("t6_rst_temt", bus.temt, 1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t6_quiet_txd",  bus.txd,  1);
    check("t6_quiet_temt", bus.temt, 1);
    write_byte(8'h00);
    lead_in("t6b");
    check_frame("t6b", {1'b1, 8'h00, 1'b0}, 10, 16, 16, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
